// File: rtl/wb_exc_stage_pkg.sv
// Shared constants and types for the write-back / exception stage.
// Excodes, CP0 register addresses ({rd, sel}) and the exception vector.
package wb_exc_stage_pkg;

    localparam logic [31:0] EXC_ENTRY = 32'hbfc00380;

    localparam logic [4:0] EX_INT  = 5'h00;
    localparam logic [4:0] EX_ADEL = 5'h04;
    localparam logic [4:0] EX_ADES = 5'h05;
    localparam logic [4:0] EX_SYS  = 5'h08;
    localparam logic [4:0] EX_BP   = 5'h09;
    localparam logic [4:0] EX_RI   = 5'h0a;
    localparam logic [4:0] EX_OV   = 5'h0c;

    localparam logic [7:0] CR_BADVADDR = 8'h40;
    localparam logic [7:0] CR_COUNT    = 8'h48;
    localparam logic [7:0] CR_COMPARE  = 8'h58;
    localparam logic [7:0] CR_STATUS   = 8'h60;
    localparam logic [7:0] CR_CAUSE    = 8'h68;
    localparam logic [7:0] CR_EPC      = 8'h70;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        ex;
        logic [4:0]  excode;
        logic        bd;
        logic [31:0] badvaddr;
        logic        eret;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  c0_addr;
    } ws_data_t;

endpackage

// File: rtl/wb_exc_stage.sv
// Write-back stage: commits GPR/CP0 writes, arbitrates exceptions and interrupts,
// and drives the pipeline flush and redirect PC.
module wb_exc_stage
    import wb_exc_stage_pkg::*;
#(
    parameter logic [31:0] ExcEntry = EXC_ENTRY,
    parameter logic [4:0]  ExcInt   = EX_INT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic        ms_gr_we,
    input  logic [4:0]  ms_dest,
    input  logic [31:0] ms_result,
    input  logic        ms_ex,
    input  logic [4:0]  ms_excode,
    input  logic        ms_bd,
    input  logic [31:0] ms_badvaddr,
    input  logic        ms_eret,
    input  logic        ms_mtc0,
    input  logic        ms_mfc0,
    input  logic [7:0]  ms_c0_addr,

    input  logic        has_int,
    input  logic [31:0] c0_rdata,
    input  logic [31:0] c0_epc,

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,

    output logic        mtc0_we,
    output logic [7:0]  c0_raddr,
    output logic [31:0] c0_wdata,

    output logic        wb_ex,
    output logic [4:0]  wb_excode,
    output logic        wb_bd,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_badvaddr,
    output logic        eret_flush,

    output logic        ws_flush,
    output logic [31:0] flush_pc,

    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    logic     r_valid;
    ws_data_t r_data;

    logic     w_ready_go;
    logic     w_allowin;
    logic     w_take_int;
    logic     w_ex;
    logic     w_rf_we;
    logic     w_eret;
    logic     w_flush;
    logic [31:0] w_rf_wdata;
    ws_data_t w_ms_data;

    always_comb begin
        w_ms_data.pc       = ms_pc;
        w_ms_data.gr_we    = ms_gr_we;
        w_ms_data.dest     = ms_dest;
        w_ms_data.result   = ms_result;
        w_ms_data.ex       = ms_ex;
        w_ms_data.excode   = ms_excode;
        w_ms_data.bd       = ms_bd;
        w_ms_data.badvaddr = ms_badvaddr;
        w_ms_data.eret     = ms_eret;
        w_ms_data.mtc0     = ms_mtc0;
        w_ms_data.mfc0     = ms_mfc0;
        w_ms_data.c0_addr  = ms_c0_addr;
    end

    assign w_ready_go = 1'b1;
    assign w_allowin  = !r_valid || w_ready_go;

    // An interrupt overrides whatever exception the instruction carried.
    assign w_take_int = r_valid && has_int;
    assign w_ex       = w_take_int || (r_valid && r_data.ex);
    assign w_rf_we    = r_valid && r_data.gr_we && !w_ex;
    assign w_eret     = r_valid && r_data.eret && !w_ex;
    assign w_flush    = w_ex || w_eret;
    assign w_rf_wdata = r_data.mfc0 ? c0_rdata : r_data.result;

    // A flush discards whatever the memory stage offers in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (w_flush) begin
            r_valid <= 1'b0;
        end else if (w_allowin) begin
            r_valid <= ms_to_ws_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ms_to_ws_valid && w_allowin && !w_flush) begin
            r_data <= w_ms_data;
        end
    end

    assign ws_allowin = w_allowin;

    assign rf_we    = w_rf_we;
    assign rf_waddr = r_data.dest;
    assign rf_wdata = w_rf_wdata;

    assign mtc0_we  = r_valid && r_data.mtc0 && !w_ex;
    assign c0_raddr = r_data.c0_addr;
    assign c0_wdata = r_data.result;

    assign wb_ex       = w_ex;
    assign wb_excode   = w_take_int ? ExcInt : r_data.excode;
    assign wb_bd       = r_data.bd;
    assign wb_pc       = r_data.pc;
    assign wb_badvaddr = r_data.badvaddr;
    assign eret_flush  = w_eret;

    // EPC is read combinationally, before this cycle's CP0 update lands.
    assign ws_flush = w_flush;
    assign flush_pc = w_ex ? ExcEntry : c0_epc;

    assign debug_wb_pc       = r_data.pc;
    assign debug_wb_rf_wen   = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = r_data.dest;
    assign debug_wb_rf_wdata = w_rf_wdata;

endmodule

// File: tb/tb_wb_exc_stage.sv
// Scoreboard bench for wb_exc_stage: a stimulus table drives the memory-stage side,
// expected commits are queued at issue and compared one cycle later.
module tb_wb_exc_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        ms_ex;
    logic [4:0]  ms_excode;
    logic        ms_bd;
    logic [31:0] ms_badvaddr;
    logic        ms_eret;
    logic        ms_mtc0;
    logic        ms_mfc0;
    logic [7:0]  ms_c0_addr;
    logic        has_int;
    logic [31:0] c0_rdata;
    logic [31:0] c0_epc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mtc0_we;
    logic [7:0]  c0_raddr;
    logic [31:0] c0_wdata;
    logic        wb_ex;
    logic [4:0]  wb_excode;
    logic        wb_bd;
    logic [31:0] wb_pc;
    logic [31:0] wb_badvaddr;
    logic        eret_flush;
    logic        ws_flush;
    logic [31:0] flush_pc;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    wb_exc_stage u_dut (
        .clk               (clk),
        .reset             (reset),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ws_allowin        (ws_allowin),
        .ms_pc             (ms_pc),
        .ms_gr_we          (ms_gr_we),
        .ms_dest           (ms_dest),
        .ms_result         (ms_result),
        .ms_ex             (ms_ex),
        .ms_excode         (ms_excode),
        .ms_bd             (ms_bd),
        .ms_badvaddr       (ms_badvaddr),
        .ms_eret           (ms_eret),
        .ms_mtc0           (ms_mtc0),
        .ms_mfc0           (ms_mfc0),
        .ms_c0_addr        (ms_c0_addr),
        .has_int           (has_int),
        .c0_rdata          (c0_rdata),
        .c0_epc            (c0_epc),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .mtc0_we           (mtc0_we),
        .c0_raddr          (c0_raddr),
        .c0_wdata          (c0_wdata),
        .wb_ex             (wb_ex),
        .wb_excode         (wb_excode),
        .wb_bd             (wb_bd),
        .wb_pc             (wb_pc),
        .wb_badvaddr       (wb_badvaddr),
        .eret_flush        (eret_flush),
        .ws_flush          (ws_flush),
        .flush_pc          (flush_pc),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    // Minimal CP0 register file driven by the DUT's write strobe.
    logic [31:0] cp0 [256] = '{default: 32'h0};
    always @(posedge clk) if (mtc0_we) cp0[c0_raddr] <= c0_wdata;
    assign c0_rdata = cp0[c0_raddr];
    assign c0_epc   = cp0[8'h70];

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        ex;
        logic [4:0]  excode;
        logic        bd;
        logic [31:0] badv;
        logic        eret;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  c0a;
        logic        intc;
    } stim_t;

    typedef struct {
        logic        valid;
        logic        int_drv;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wb_ex;
        logic [4:0]  excode;
        logic        bd;
        logic [31:0] pc;
        logic [31:0] badv;
        logic        mtc0_we;
        logic [7:0]  c0a;
        logic [31:0] c0w;
        logic        eret;
        logic        flush;
        logic [31:0] fpc;
    } exp_t;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_cp0 [256] = '{default: 32'h0};
    stim_t stims[$];
    exp_t  sb[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic stim_t alu(input logic [31:0] pc, input logic [4:0] dest,
                                  input logic [31:0] res);
        stim_t s;
        s = '{rst: 1'b0, v: 1'b1, pc: pc, gr_we: 1'b1, dest: dest, result: res, ex: 1'b0,
              excode: 5'h0, bd: 1'b0, badv: 32'h0, eret: 1'b0, mtc0: 1'b0, mfc0: 1'b0,
              c0a: 8'h0, intc: 1'b0};
        return s;
    endfunction

    function automatic exp_t empty_exp();
        exp_t e;
        e = '{valid: 1'b0, int_drv: 1'b1, rf_we: 1'b0, waddr: 5'h0, wdata: 32'h0,
              wb_ex: 1'b0, excode: 5'h0, bd: 1'b0, pc: 32'h0, badv: 32'h0, mtc0_we: 1'b0,
              c0a: 8'h0, c0w: 32'h0, eret: 1'b0, flush: 1'b0, fpc: 32'h0};
        return e;
    endfunction

    function automatic exp_t make_exp(input stim_t s);
        exp_t e;
        e         = empty_exp();
        e.valid   = 1'b1;
        e.int_drv = s.intc;
        e.wb_ex   = s.intc || s.ex;
        e.excode  = s.intc ? 5'h00 : s.excode;
        e.rf_we   = s.gr_we && !e.wb_ex;
        e.waddr   = s.dest;
        e.wdata   = s.mfc0 ? exp_cp0[s.c0a] : s.result;
        e.bd      = s.bd;
        e.pc      = s.pc;
        e.badv    = s.badv;
        e.mtc0_we = s.mtc0 && !e.wb_ex;
        e.c0a     = s.c0a;
        e.c0w     = s.result;
        e.eret    = s.eret && !e.wb_ex;
        e.flush   = e.wb_ex || e.eret;
        e.fpc     = e.wb_ex ? 32'hbfc00380 : exp_cp0[8'h70];
        return e;
    endfunction

    task automatic drive(input stim_t s);
        ms_to_ws_valid = s.v;
        ms_pc          = s.pc;
        ms_gr_we       = s.gr_we;
        ms_dest        = s.dest;
        ms_result      = s.result;
        ms_ex          = s.ex;
        ms_excode      = s.excode;
        ms_bd          = s.bd;
        ms_badvaddr    = s.badv;
        ms_eret        = s.eret;
        ms_mtc0        = s.mtc0;
        ms_mfc0        = s.mfc0;
        ms_c0_addr     = s.c0a;
    endtask

    task automatic compare(input exp_t e);
        check("ws_allowin", 32'(ws_allowin), 32'd1);
        check("rf_we", 32'(rf_we), 32'(e.rf_we));
        check("wb_ex", 32'(wb_ex), 32'(e.wb_ex));
        check("mtc0_we", 32'(mtc0_we), 32'(e.mtc0_we));
        check("eret_flush", 32'(eret_flush), 32'(e.eret));
        check("ws_flush", 32'(ws_flush), 32'(e.flush));
        check("dbg_wen", 32'(debug_wb_rf_wen), 32'({4{e.rf_we}}));
        if (e.valid) begin
            check("wb_pc", wb_pc, e.pc);
            check("dbg_pc", debug_wb_pc, e.pc);
            check("wb_bd", 32'(wb_bd), 32'(e.bd));
            check("wb_badvaddr", wb_badvaddr, e.badv);
            check("c0_raddr", 32'(c0_raddr), 32'(e.c0a));
            if (e.rf_we) begin
                check("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                check("rf_wdata", rf_wdata, e.wdata);
                check("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(e.waddr));
                check("dbg_wdata", debug_wb_rf_wdata, e.wdata);
            end
            if (e.wb_ex) check("wb_excode", 32'(wb_excode), 32'(e.excode));
            if (e.flush) check("flush_pc", flush_pc, e.fpc);
            if (e.mtc0_we) check("c0_wdata", c0_wdata, e.c0w);
        end
    endtask

    initial begin
        stim_t s;
        exp_t  e;
        exp_t  n;

        // Build the stimulus table.
        stims.push_back(alu(32'hbfc00010, 5'd3, 32'h0000_1234));
        s = alu(32'hbfc00014, 5'd5, 32'h0000_0055);
        s.ex = 1'b1; s.excode = 5'd4; s.badv = 32'h0000_1001; s.bd = 1'b1;
        stims.push_back(s);
        stims.push_back(alu(32'hbfc00018, 5'd6, 32'h0000_0077));   // offered during flush
        stims.push_back(alu(32'hbfc00380, 5'd7, 32'h0000_a5a5));
        s = alu(32'hbfc00384, 5'd0, 32'hbfc00100);
        s.gr_we = 1'b0; s.mtc0 = 1'b1; s.c0a = 8'h70;
        stims.push_back(s);
        s = alu(32'hbfc00388, 5'd0, 32'h0);
        s.gr_we = 1'b0; s.eret = 1'b1;
        stims.push_back(s);
        stims.push_back(alu(32'hbfc0038c, 5'd8, 32'h0000_0088));   // dropped by ERET
        s = alu(32'hbfc00100, 5'd9, 32'h0000_0099);
        s.ex = 1'b1; s.excode = 5'd10; s.intc = 1'b1;
        stims.push_back(s);
        stims.push_back(alu(32'hbfc00104, 5'd9, 32'h0000_0999));   // dropped
        s = alu(32'hbfc00380, 5'd0, 32'h00c0_ffee);
        s.gr_we = 1'b0; s.mtc0 = 1'b1; s.c0a = 8'h58;
        stims.push_back(s);
        s = alu(32'hbfc00384, 5'd10, 32'hdead_beef);
        s.mfc0 = 1'b1; s.c0a = 8'h58;
        stims.push_back(s);
        s = alu(32'hbfc00388, 5'd0, 32'h0);
        s.gr_we = 1'b0; s.eret = 1'b1; s.intc = 1'b1;
        stims.push_back(s);
        stims.push_back(alu(32'hbfc0038c, 5'd2, 32'h0000_0002));   // dropped
        stims.push_back(alu(32'hbfc00380, 5'd11, 32'h0000_0011));
        s = alu(32'hbfc00384, 5'd12, 32'h0000_0012);
        s.rst = 1'b1;                                              // reset with stage valid
        stims.push_back(s);
        s = alu(32'hbfc00388, 5'd13, 32'h0000_0013);
        s.v = 1'b0;
        stims.push_back(s);
        stims.push_back(alu(32'hbfc0038c, 5'd14, 32'h1111_2222));
        stims.push_back(alu(32'hbfc00390, 5'd15, 32'h3333_4444));

        reset   = 1'b1;
        has_int = 1'b0;
        drive(alu(32'hbfc00000, 5'd1, 32'h1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        has_int = 1'b1;
        #1;
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_wb_ex", 32'(wb_ex), 32'd0);
        check("rst_allowin", 32'(ws_allowin), 32'd1);
        check("rst_flush", 32'(ws_flush), 32'd0);
        check("rst_eret", 32'(eret_flush), 32'd0);
        sb.push_back(empty_exp());

        for (int i = 0; i < stims.size(); i++) begin
            s = stims[i];
            e = sb.pop_front();
            has_int = e.int_drv;
            reset   = s.rst;
            drive(s);
            #1;
            compare(e);
            if (s.rst || !s.v || e.flush) begin
                n = empty_exp();
            end else begin
                n = make_exp(s);
                if (n.mtc0_we) exp_cp0[n.c0a] = n.c0w;
            end
            sb.push_back(n);
            @(negedge clk);
        end

        e = sb.pop_front();
        has_int = e.int_drv;
        reset   = 1'b0;
        ms_to_ws_valid = 1'b0;
        #1;
        compare(e);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
